// File: rtl/acc_ctrl_if.sv
// Bundles the command, ALU-drive and result channels of alu_acc_ctrl.
// master = the controller itself; slave = the command source, ALU and result sink.
interface acc_ctrl_if #(
  parameter int RPT_W = 4
);
  logic             acc_clr_in;
  logic             acc_cmd_valid_in;
  logic             acc_cmd_ready_out;
  logic             acc_cmd_load_in;
  logic [4:0]       acc_cmd_sel_in;
  logic             acc_cmd_carry_in;
  logic [7:0]       acc_cmd_b_in;
  logic [RPT_W-1:0] acc_cmd_rpt_in;
  logic [4:0]       acc_alu_sel_out;
  logic             acc_alu_carry_out;
  logic [7:0]       acc_alu_a_out;
  logic [7:0]       acc_alu_b_out;
  logic [7:0]       acc_alu_y_in;
  logic             acc_res_valid_out;
  logic             acc_res_ready_in;
  logic [7:0]       acc_res_data_out;
  logic             acc_res_zero_out;
  logic             acc_busy_out;

  modport master (
    input  acc_clr_in, acc_cmd_valid_in, acc_cmd_load_in, acc_cmd_sel_in,
           acc_cmd_carry_in, acc_cmd_b_in, acc_cmd_rpt_in, acc_alu_y_in,
           acc_res_ready_in,
    output acc_cmd_ready_out, acc_alu_sel_out, acc_alu_carry_out, acc_alu_a_out,
           acc_alu_b_out, acc_res_valid_out, acc_res_data_out, acc_res_zero_out,
           acc_busy_out
  );

  modport slave (
    output acc_clr_in, acc_cmd_valid_in, acc_cmd_load_in, acc_cmd_sel_in,
           acc_cmd_carry_in, acc_cmd_b_in, acc_cmd_rpt_in, acc_alu_y_in,
           acc_res_ready_in,
    input  acc_cmd_ready_out, acc_alu_sel_out, acc_alu_carry_out, acc_alu_a_out,
           acc_alu_b_out, acc_res_valid_out, acc_res_data_out, acc_res_zero_out,
           acc_busy_out
  );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Accumulator command sequencer in front of an 8-bit combinational ALU, with repeat counts.
// Optional: define ACC_CTRL_ZSTOP_EN to end an ALU command early on a zero result.
module alu_acc_ctrl #(
  parameter logic [7:0] ACC_RESET_VAL = 8'h00,
  parameter int         RPT_W         = 4
) (
  input  logic      acc_clk_in,
  input  logic      acc_rst_n_in,
  acc_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t           state, state_nxt;
  logic [7:0]       acc;
  logic [7:0]       b_q;
  logic [4:0]       sel_q;
  logic             carry_q;
  logic [RPT_W-1:0] cnt;
  logic [7:0]       res_data;
  logic             res_zero;
  logic             accept;
  logic             exec_done;

  assign bus.acc_cmd_ready_out = (state == IDLE) && !bus.acc_clr_in && acc_rst_n_in;
  assign accept                = bus.acc_cmd_valid_in && bus.acc_cmd_ready_out;

`ifdef ACC_CTRL_ZSTOP_EN
  assign exec_done = (cnt == '0) || (bus.acc_alu_y_in == 8'h00);
`else
  assign exec_done = (cnt == '0);
`endif

  // The ALU only sees the latched command while iterating; otherwise it idles on A.
  assign bus.acc_alu_sel_out   = (state == EXEC) ? sel_q   : 5'd0;
  assign bus.acc_alu_carry_out = (state == EXEC) ? carry_q : 1'b0;
  assign bus.acc_alu_b_out     = (state == EXEC) ? b_q     : 8'h00;
  assign bus.acc_alu_a_out     = acc;

  assign bus.acc_res_valid_out = (state == HOLD);
  assign bus.acc_res_data_out  = res_data;
  assign bus.acc_res_zero_out  = res_zero;
  assign bus.acc_busy_out      = (state != IDLE);

  // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge acc_clk_in or negedge acc_rst_n_in) begin
    if (!acc_rst_n_in) state <= IDLE;
    else               state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = bus.acc_cmd_load_in ? HOLD : EXEC;
      EXEC: if (exec_done) state_nxt = HOLD;
      HOLD: if (bus.acc_res_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge acc_clk_in or negedge acc_rst_n_in) begin
    if (!acc_rst_n_in) begin
      acc      <= ACC_RESET_VAL;
      b_q      <= 8'h00;
      sel_q    <= 5'd0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      res_data <= 8'h00;
      res_zero <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.acc_clr_in) begin
            acc <= ACC_RESET_VAL;
          end else if (accept) begin
            sel_q   <= bus.acc_cmd_sel_in;
            carry_q <= bus.acc_cmd_carry_in;
            b_q     <= bus.acc_cmd_b_in;
            if (bus.acc_cmd_load_in) begin
              acc      <= bus.acc_cmd_b_in;
              res_data <= bus.acc_cmd_b_in;
              res_zero <= (bus.acc_cmd_b_in == 8'h00);
            end else begin
              cnt <= bus.acc_cmd_rpt_in;
            end
          end
        end
        EXEC: begin
          acc <= bus.acc_alu_y_in;
          if (exec_done) begin
            res_data <= bus.acc_alu_y_in;
            res_zero <= (bus.acc_alu_y_in == 8'h00);
          end else begin
            cnt <= cnt - RPT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Bench for alu_acc_ctrl: an ALU model closes the loop; directed table, clear, reset and random commands.
module tb_alu_acc_ctrl;
  localparam int         RPT_W   = 4;
  localparam logic [7:0] RST_VAL = 8'h00;
  localparam int         MAX_LAT = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_ctrl_if #(.RPT_W(RPT_W)) bus ();

  alu_acc_ctrl #(.ACC_RESET_VAL(RST_VAL), .RPT_W(RPT_W)) dut (
    .acc_clk_in  (clk),
    .acc_rst_n_in(rst_n),
    .bus         (bus)
  );

  // Behavioural 8-bit ALU standing in for the real one downstream.
  function automatic logic [7:0] alu(input logic [4:0] sel, input logic cin,
                                     input logic [7:0] a, input logic [7:0] b);
    case (sel)
      5'd1:    return a + b + {7'd0, cin};
      5'd2:    return a - b;
      5'd3:    return a - 8'd1;
      5'd4:    return a & b;
      5'd5:    return a | b;
      5'd6:    return a ^ b;
      5'd8:    return a << 1;
      5'd9:    return a >> 1;
      default: return a;
    endcase
  endfunction

  assign bus.acc_alu_y_in = alu(bus.acc_alu_sel_out, bus.acc_alu_carry_out,
                                bus.acc_alu_a_out, bus.acc_alu_b_out);

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: apply the operation rpt+1 times (or stop early on zero when enabled).
  task automatic ref_cmd(input logic [7:0] acc0, input logic load, input logic [4:0] sel,
                         input logic cin, input logic [7:0] b, input int rpt,
                         output logic [7:0] data, output int lat);
    logic [7:0] a;
    int iters;
    if (load) begin
      data = b;
      lat  = 1;
    end else begin
      a     = acc0;
      iters = 0;
      for (int i = 0; i <= rpt; i++) begin
        a = alu(sel, cin, a, b);
        iters++;
`ifdef ACC_CTRL_ZSTOP_EN
        if (a == 8'h00) break;
`endif
      end
      data = a;
      lat  = iters + 1;
    end
  endtask

  task automatic run_cmd(input string tag, input logic load, input logic [4:0] sel,
                         input logic cin, input logic [7:0] b, input int rpt,
                         input logic [7:0] exp_data, input int exp_lat, input int hold);
    logic [7:0] exp_a;
    int lat;
    @(negedge clk);
    check({tag, " cmd_ready idle"}, bus.acc_cmd_ready_out, 1);
    bus.acc_cmd_load_in  = load;
    bus.acc_cmd_sel_in   = sel;
    bus.acc_cmd_carry_in = cin;
    bus.acc_cmd_b_in     = b;
    bus.acc_cmd_rpt_in   = RPT_W'(rpt);
    bus.acc_cmd_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.acc_cmd_valid_in = 1'b0;
    exp_a = m_acc;
    lat   = 1;
    while (!bus.acc_res_valid_out && lat < MAX_LAT) begin
      check({tag, " exec busy"}, bus.acc_busy_out, 1);
      check({tag, " exec alu_sel"}, bus.acc_alu_sel_out, sel);
      check({tag, " exec alu_a"}, bus.acc_alu_a_out, exp_a);
      exp_a = alu(sel, cin, exp_a, b);
      @(negedge clk);
      lat++;
    end
    if (!bus.acc_res_valid_out) begin
      check({tag, " result timeout"}, 0, 1);
      return;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " res_data"}, bus.acc_res_data_out, exp_data);
    check({tag, " res_zero"}, bus.acc_res_zero_out, exp_data == 8'h00);
    check({tag, " accumulator"}, bus.acc_alu_a_out, exp_data);
    check({tag, " cmd_ready hold"}, bus.acc_cmd_ready_out, 0);
    m_acc = exp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " bp valid"}, bus.acc_res_valid_out, 1);
      check({tag, " bp data"}, bus.acc_res_data_out, exp_data);
      check({tag, " bp zero"}, bus.acc_res_zero_out, exp_data == 8'h00);
      check({tag, " bp cmd_ready"}, bus.acc_cmd_ready_out, 0);
    end
    bus.acc_res_ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.acc_res_ready_in = 1'b0;
    check({tag, " done valid"}, bus.acc_res_valid_out, 0);
    check({tag, " done busy"}, bus.acc_busy_out, 0);
    check({tag, " done cmd_ready"}, bus.acc_cmd_ready_out, 1);
  endtask

  typedef struct {
    logic       load;
    logic [4:0] sel;
    logic       cin;
    logic [7:0] b;
    int         rpt;
    logic [7:0] exp_data;
    int         exp_lat;
    int         hold;
  } vec_t;

  vec_t vecs[8];
  logic [4:0] sel_pool[8];

  initial begin
    logic [7:0] r_data;
    int r_lat;
    logic r_load;
    logic [4:0] r_sel;
    logic r_cin;
    logic [7:0] r_b;
    int r_rpt;
    logic saw_valid;

    vecs[0] = '{1'b1, 5'd0, 1'b0, 8'h05, 0,  8'h05, 1,  0};
    vecs[1] = '{1'b0, 5'd1, 1'b0, 8'h03, 0,  8'h08, 2,  0};
    vecs[2] = '{1'b0, 5'd8, 1'b0, 8'h00, 2,  8'h40, 4,  5};
    vecs[3] = '{1'b1, 5'd0, 1'b0, 8'h03, 0,  8'h03, 1,  0};
`ifdef ACC_CTRL_ZSTOP_EN
    vecs[4] = '{1'b0, 5'd3, 1'b0, 8'h00, 7,  8'h00, 4,  1};
`else
    vecs[4] = '{1'b0, 5'd3, 1'b0, 8'h00, 7,  8'hFB, 9,  1};
`endif
    vecs[5] = '{1'b1, 5'd0, 1'b0, 8'h01, 0,  8'h01, 1,  0};
    vecs[6] = '{1'b0, 5'd1, 1'b1, 8'h00, 15, 8'h11, 17, 2};
    vecs[7] = '{1'b0, 5'd1, 1'b1, 8'hFF, 0,  8'h11, 2,  0};
    sel_pool = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};

    bus.acc_clr_in       = 1'b0;
    bus.acc_cmd_valid_in = 1'b0;
    bus.acc_cmd_load_in  = 1'b0;
    bus.acc_cmd_sel_in   = 5'd0;
    bus.acc_cmd_carry_in = 1'b0;
    bus.acc_cmd_b_in     = 8'h00;
    bus.acc_cmd_rpt_in   = '0;
    bus.acc_res_ready_in = 1'b0;

    #12;
    check("reset cmd_ready", bus.acc_cmd_ready_out, 0);
    check("reset res_valid", bus.acc_res_valid_out, 0);
    check("reset busy", bus.acc_busy_out, 0);
    check("reset res_data", bus.acc_res_data_out, 8'h00);
    check("reset res_zero", bus.acc_res_zero_out, 1);
    check("reset accumulator", bus.acc_alu_a_out, RST_VAL);
    check("reset alu_sel", bus.acc_alu_sel_out, 0);
    check("reset alu_b", bus.acc_alu_b_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = RST_VAL;

    for (int i = 0; i < 8; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].load, vecs[i].sel, vecs[i].cin, vecs[i].b,
              vecs[i].rpt, vecs[i].exp_data, vecs[i].exp_lat, vecs[i].hold);

    // Clear and a load command in the same idle cycle: clear wins, command dropped.
    @(negedge clk);
    bus.acc_clr_in       = 1'b1;
    bus.acc_cmd_valid_in = 1'b1;
    bus.acc_cmd_load_in  = 1'b1;
    bus.acc_cmd_b_in     = 8'h77;
    #1;
    check("clr cmd_ready", bus.acc_cmd_ready_out, 0);
    @(posedge clk);
    @(negedge clk);
    bus.acc_clr_in       = 1'b0;
    bus.acc_cmd_valid_in = 1'b0;
    check("clr res_valid", bus.acc_res_valid_out, 0);
    check("clr busy", bus.acc_busy_out, 0);
    check("clr accumulator", bus.acc_alu_a_out, RST_VAL);
    m_acc = RST_VAL;

    for (int i = 0; i < 40; i++) begin
      r_load = ($urandom_range(0, 3) == 0);
      r_sel  = sel_pool[$urandom_range(0, 7)];
      r_cin  = 1'($urandom_range(0, 1));
      r_b    = 8'($urandom_range(0, 255));
      r_rpt  = $urandom_range(0, 15);
      ref_cmd(m_acc, r_load, r_sel, r_cin, r_b, r_rpt, r_data, r_lat);
      run_cmd($sformatf("rnd%0d", i), r_load, r_load ? 5'd0 : r_sel, r_cin, r_b, r_rpt,
              r_data, r_lat, $urandom_range(0, 3));
    end

    // Reset in the middle of a repeated add: command aborted, nothing presented afterwards.
    run_cmd("pre_rst", 1'b1, 5'd0, 1'b0, 8'h10, 0, 8'h10, 1, 0);
    @(negedge clk);
    bus.acc_cmd_load_in  = 1'b0;
    bus.acc_cmd_sel_in   = 5'd1;
    bus.acc_cmd_carry_in = 1'b0;
    bus.acc_cmd_b_in     = 8'h01;
    bus.acc_cmd_rpt_in   = RPT_W'(7);
    bus.acc_cmd_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.acc_cmd_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy", bus.acc_busy_out, 1);
    check("mid accumulator", bus.acc_alu_a_out, 8'h13);
    rst_n = 1'b0;
    #1;
    check("abort accumulator", bus.acc_alu_a_out, RST_VAL);
    check("abort res_valid", bus.acc_res_valid_out, 0);
    check("abort busy", bus.acc_busy_out, 0);
    check("abort cmd_ready", bus.acc_cmd_ready_out, 0);
    check("abort res_zero", bus.acc_res_zero_out, 1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.acc_res_valid_out || bus.acc_busy_out) saw_valid = 1'b1;
    end
    check("post-abort idle", saw_valid, 0);
    m_acc = RST_VAL;
    run_cmd("post_rst", 1'b0, 5'd1, 1'b0, 8'h02, 1, 8'h04, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_acc_ctrl.md
# alu_acc_ctrl

Accumulator-based command sequencer that sits directly upstream of the 8-bit ALU. It drives the ALU's select, carry and operand inputs, and captures the ALU result into an internal accumulator. It returns each result over a valid/ready handshake. Repeat counts let a single command iterate the same ALU operation several times: shift loops, countdowns and repeated accumulation.

## Interface
- ACC_RESET_VAL, 8'h00, accumulator value after reset or clear
- RPT_W, 4, width of the repeat-count field
- acc_clk_in  in  1  clock; all state changes on rising edge
- acc_rst_n_in  in  1  reset; one clock; reset is asynchronous and active-low
- acc_clr_in  in  1  synchronous accumulator clear, honoured in IDLE only
- acc_cmd_valid_in  in  1  command valid
- acc_cmd_ready_out  out  1  command ready
- acc_cmd_load_in  in  1  1 = load acc_cmd_b_in into accumulator, bypassing the ALU
- acc_cmd_sel_in  in  5  ALU select code for the command
- acc_cmd_carry_in  in  1  ALU carry-in for the command
- acc_cmd_b_in  in  8  B operand, or load data
- acc_cmd_rpt_in  in  RPT_W  extra iterations; operation executes rpt+1 times
- acc_alu_sel_out  out  5  to ALU select
- acc_alu_carry_out  out  1  to ALU carry-in
- acc_alu_a_out  out  8  to ALU A; always the accumulator
- acc_alu_b_out  out  8  to ALU B
- acc_alu_y_in  in  8  from ALU result (combinational path through ALU)
- acc_res_valid_out  out  1  result valid
- acc_res_ready_in  in  1  result ready
- acc_res_data_out  out  8  result; equals accumulator at completion
- acc_res_zero_out  out  1  1 when acc_res_data_out == 0
- acc_busy_out  out  1  1 in EXEC or HOLD

## Operation
- States: IDLE, EXEC, HOLD.
- acc_cmd_ready_out = (state==IDLE) & !acc_clr_in & reset deasserted.
- IDLE with clear:
  - acc_clr_in=1 sets accumulator to ACC_RESET_VAL.
  - No command is accepted that cycle; clear wins over a simultaneous command.
- IDLE, command accept (valid & ready): latch sel, carry, b and rpt into command registers.
  - Load command: accumulator <= b, res_data <= b, go to HOLD.
  - Otherwise: counter <= rpt, go to EXEC.
- EXEC, every cycle:
  - ALU is driven with latched sel/carry, A = accumulator, B = latched b; accumulator <= acc_alu_y_in.
  - counter==0: res_data <= acc_alu_y_in, go to HOLD.
  - Otherwise: decrement counter and stay in EXEC.
- HOLD: res_valid=1; when acc_res_ready_in=1, go to IDLE on the next edge. res_data and zero are held stable until then.
- Outside EXEC, ALU drive is sel=0, carry=0, A = accumulator, B = 8'h00.
- Arithmetic is modulo 2^8 in the ALU; this block adds no carry or overflow logic. Counter is RPT_W bits and does not wrap: EXEC exits at 0.
- acc_clr_in is ignored in EXEC and HOLD.
- acc_res_zero_out is registered together with acc_res_data_out.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; accumulator = ACC_RESET_VAL; counter = 0.
  - res_data = 8'h00; res_zero = 1; res_valid = 0; busy = 0; cmd_ready = 0 while reset is asserted.
- Command accepted at edge T:
  - Load: res_valid high from T+1.
  - ALU command: EXEC occupies cycles T+1 through T+1+rpt; res_valid high from T+2+rpt.
- Reset asserted mid-EXEC or mid-HOLD aborts the command; no result is presented after release.
- One command in flight at a time. A new command can be accepted no earlier than the cycle after the HOLD handshake completes.

## Configuration
- ACC_CTRL_ZSTOP_EN defined: EXEC also exits to HOLD when acc_alu_y_in == 0 in any iteration, regardless of counter. res_data = 0, res_zero = 1.
- ACC_CTRL_ZSTOP_EN undefined: always exactly rpt+1 iterations.

## Test plan
- Reset release, load b=0x05 -> res_valid at T+1, data 0x05, zero 0, accumulator 0x05.
- acc=0x05; sel=00001, cin=0, b=0x03, rpt=0 -> one EXEC cycle, res 0x08 valid at T+2.
- acc=0x08; sel=01000 (shl), cin=0, rpt=2 -> 0x10, 0x20, 0x40 in successive cycles; res 0x40 at T+4.
- acc=0x03; sel=00011, cin=0 (A-1), rpt=7:
  - With ACC_CTRL_ZSTOP_EN: res 0x00, zero 1, valid at T+4.
  - Without: res 0xFB, zero 0, valid at T+9.
- Backpressure: res_ready=0 for 5 cycles -> data, zero and valid stable; cmd_ready 0 throughout. Ready=1 -> IDLE next cycle, cmd_ready 1.
- Clear plus command in the same IDLE cycle -> accumulator = ACC_RESET_VAL and command not accepted.
- Reset mid-EXEC (rpt=7, after 3 iterations) -> accumulator = ACC_RESET_VAL, res_valid 0, no result appears after release.
